// File: rtl/mem_block_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one word-wide memory port
// between an instruction-fill requester (port 0) and a data requester (port 1).
module mem_block_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WORDS = 16,
  localparam int IDXW       = $clog2(BLOCK_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic                  o_done0,
  output logic                  o_done1,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [IDXW-1:0]       o_word_idx,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_access
);

  localparam int OFFW = $clog2(BLOCK_WORDS * 4);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = {{(ADDR_WIDTH-OFFW){1'b0}}, {OFFW{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    last_gnt_r;
  logic                    gnt_id_r;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [IDXW-1:0]         word_idx_r;
  logic                    rvalid_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic                    req_any_s;
  logic                    pick_s;
  logic                    last_access_s;

  // Arbitration: a tie goes to the port that was not served last.
  always_comb begin
    req_any_s     = i_req0 | i_req1;
    last_access_s = i_mem_access & (word_idx_r == LAST_IDX);
    if (i_req0 && i_req1) begin
      pick_s = ~last_gnt_r;
    end else if (i_req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_access_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Burst context, word counter and registered read-return path.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      last_gnt_r <= 1'b1;
      gnt_id_r   <= 1'b0;
      we_r       <= 1'b0;
      base_r     <= {ADDR_WIDTH{1'b0}};
      word_idx_r <= {IDXW{1'b0}};
      rvalid_r   <= 1'b0;
      rdata_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      rvalid_r <= (state_r == ST_BUSY) & i_mem_access & ~we_r;
      if ((state_r == ST_BUSY) && i_mem_access && !we_r) begin
        rdata_r <= i_mem_rdata;
      end
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            gnt_id_r   <= pick_s;
            we_r       <= pick_s ? i_we1 : i_we0;
            base_r     <= (pick_s ? i_addr1 : i_addr0) & ~BLK_MASK;
            word_idx_r <= {IDXW{1'b0}};
          end
        end
        ST_BUSY: begin
          // The counter wraps only on the final access, as the burst leaves BUSY.
          if (last_access_s) begin
            word_idx_r <= {IDXW{1'b0}};
          end else if (i_mem_access) begin
            word_idx_r <= word_idx_r + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: last_gnt_r <= gnt_id_r;
        default: last_gnt_r <= last_gnt_r;
      endcase
    end
  end

  // Output decode from the registered state and burst context.
  always_comb begin
    o_gnt0      = 1'b0;
    o_gnt1      = 1'b0;
    o_done0     = 1'b0;
    o_done1     = 1'b0;
    o_mem_addr  = {ADDR_WIDTH{1'b0}};
    o_mem_wdata = {DATA_WIDTH{1'b0}};
    o_mem_we    = 1'b0;
    case (state_r)
      ST_BUSY: begin
        o_gnt0      = ~gnt_id_r;
        o_gnt1      = gnt_id_r;
        o_mem_addr  = base_r + {{(ADDR_WIDTH-IDXW-2){1'b0}}, word_idx_r, 2'b00};
        o_mem_wdata = gnt_id_r ? i_wdata1 : i_wdata0;
        o_mem_we    = we_r;
      end
      ST_DONE: begin
        o_gnt0  = ~gnt_id_r;
        o_gnt1  = gnt_id_r;
        o_done0 = ~gnt_id_r;
        o_done1 = gnt_id_r;
      end
      default: begin
        o_gnt0 = 1'b0;
      end
    endcase
  end

  assign o_rvalid0  = rvalid_r & ~gnt_id_r;
  assign o_rvalid1  = rvalid_r & gnt_id_r;
  assign o_rdata    = rdata_r;
  assign o_word_idx = word_idx_r;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Scoreboard bench for mem_block_arbiter: directed bursts against a small word
// memory model; a monitor pops expected read/done events and grant order.
module tb_mem_block_arbiter;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic        i_req0, i_req1, i_we0, i_we1;
  logic [63:0] i_addr0, i_addr1;
  logic [31:0] i_wdata0, i_wdata1;
  logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_done0, o_done1;
  logic [31:0] o_rdata;
  logic [3:0]  o_word_idx;
  logic [63:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic [31:0] i_mem_rdata;
  logic        i_mem_access;

  typedef struct {
    int          kind;   // 0 read word, 1 last read word with done, 2 write done
    logic [31:0] data;
  } ev_t;

  ev_t         q0[$];
  ev_t         q1[$];
  int          gq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem  [0:4095];
  logic [31:0] emem [0:4095];
  logic        acc_en = 1'b0;
  logic        pg0 = 1'b0;
  logic        pg1 = 1'b0;

  always #5 i_clk = ~i_clk;

  mem_block_arbiter dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_done0(o_done0), .o_done1(o_done1), .o_rdata(o_rdata), .o_word_idx(o_word_idx),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .i_mem_rdata(i_mem_rdata), .i_mem_access(i_mem_access)
  );

  assign i_mem_rdata = mem[o_mem_addr[13:2]];
  assign i_wdata0    = 32'hB000_0000 + {28'd0, o_word_idx};
  assign i_wdata1    = 32'hA000_0000 + {28'd0, o_word_idx};

  // Free-running access pulses; a write lands at the edge that samples the pulse.
  initial begin
    i_mem_access = 1'b0;
    forever begin
      @(negedge i_clk);
      i_mem_access = acc_en && ($urandom_range(0, 2) != 0);
      if (i_mem_access && o_mem_we) mem[o_mem_addr[13:2]] = o_mem_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int port, input logic we, input logic [63:0] addr);
    logic [63:0] base;
    logic [63:0] a;
    ev_t         e;
    base = addr & ~64'h3F;
    gq.push_back(port);
    for (int k = 0; k < 16; k++) begin
      a = base + 64'(4 * k);
      if (we) begin
        emem[a[13:2]] = ((port == 1) ? 32'hA000_0000 : 32'hB000_0000) + 32'(k);
        e.kind = 2;
        e.data = 32'h0;
        if (k == 15) begin
          if (port == 1) q1.push_back(e); else q0.push_back(e);
        end
      end else begin
        e.kind = (k == 15) ? 1 : 0;
        e.data = emem[a[13:2]];
        if (port == 1) q1.push_back(e); else q0.push_back(e);
      end
    end
  endtask

  task automatic check_ev(input int port, input logic rv, input logic dn);
    ev_t e;
    int  k;
    if (!rv && !dn) return;
    k = (rv && dn) ? 1 : (rv ? 0 : 2);
    tests++;
    if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
      fails++;
      $display("FAIL unexpected_event port%0d: got kind %0d data %h expected none", port, k, o_rdata);
      return;
    end
    e = (port == 0) ? q0.pop_front() : q1.pop_front();
    if (e.kind != k || (k != 2 && e.data !== o_rdata)) begin
      fails++;
      $display("FAIL event port%0d: got kind %0d data %h expected kind %0d data %h",
               port, k, o_rdata, e.kind, e.data);
    end
  endtask

  task automatic check_gnt(input int port);
    int exp;
    tests++;
    if (gq.size() == 0) begin
      fails++;
      $display("FAIL grant_order: got port%0d expected no grant", port);
    end else begin
      exp = gq.pop_front();
      if (exp != port) begin
        fails++;
        $display("FAIL grant_order: got port%0d expected port%0d", port, exp);
      end
    end
  endtask

  // Monitor: compare every read word, done pulse and new grant against the queues.
  always @(negedge i_clk) begin
    if (i_arst) begin
      pg0 <= 1'b0;
      pg1 <= 1'b0;
    end else begin
      check_ev(0, o_rvalid0, o_done0);
      check_ev(1, o_rvalid1, o_done1);
      if (o_gnt0 && !pg0) check_gnt(0);
      if (o_gnt1 && !pg1) check_gnt(1);
      if (o_gnt0 && o_gnt1) check("dual_grant", 64'd1, 64'd0);
      pg0 <= o_gnt0;
      pg1 <= o_gnt1;
    end
  end

  task automatic wait_done(input int port);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!((port == 0) ? o_done0 : o_done1) && n < 3000);
    check($sformatf("done%0d_timeout", port), 64'(n >= 3000), 64'd0);
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(o_gnt0 && o_word_idx == idx) && n < 3000);
    check("word_idx_timeout", 64'(n >= 3000), 64'd0);
  endtask

  task automatic check_quiet(input string name, input logic [31:0] exp_rdata);
    check({name, "_flags"}, 64'({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_done0, o_done1, o_mem_we}), 64'd0);
    check({name, "_addr"}, o_mem_addr, 64'd0);
    check({name, "_rdata_idx"}, {28'd0, o_word_idx, o_rdata}, {32'd0, exp_rdata});
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_arst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_arst = 1'b0;
  endtask

  initial begin
    i_arst = 1'b1;
    {i_req0, i_req1, i_we0, i_we1} = 4'b0000;
    i_addr0 = 64'h0;
    i_addr1 = 64'h0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = {16'hD00D, 16'(i * 4)};
      emem[i] = {16'hD00D, 16'(i * 4)};
    end
    acc_en = 1'b1;
    repeat (3) @(negedge i_clk);
    check_quiet("reset", 32'h0);
    i_arst = 1'b0;

    // Single read on port 0; unaligned address rounds down to 0x1000.
    push_burst(0, 1'b0, 64'h1004);
    i_addr0 = 64'h1004;
    i_req0  = 1'b1;
    wait_done(0);
    i_req0  = 1'b0;

    // Both held after reset: grants alternate starting with port 0.
    do_reset();
    push_burst(0, 1'b0, 64'h0100);
    push_burst(1, 1'b0, 64'h0300);
    push_burst(0, 1'b0, 64'h0100);
    push_burst(1, 1'b0, 64'h0300);
    i_addr0 = 64'h0100;
    i_addr1 = 64'h0300;
    {i_req0, i_req1} = 2'b11;
    wait_done(0);
    wait_done(1);
    wait_done(0);
    wait_done(1);
    {i_req0, i_req1} = 2'b00;

    // Write burst on port 1, then read it back through port 0.
    push_burst(1, 1'b1, 64'h2000);
    i_addr1 = 64'h2000;
    i_we1   = 1'b1;
    i_req1  = 1'b1;
    wait_done(1);
    i_req1  = 1'b0;
    i_we1   = 1'b0;
    push_burst(0, 1'b0, 64'h2000);
    i_addr0 = 64'h2000;
    i_req0  = 1'b1;
    wait_done(0);
    i_req0  = 1'b0;
    check("mem_model_word7", 64'(mem[12'h807]), 64'h0000_0000_A000_0007);

    // Access pulses with nothing requested leave every output still.
    repeat (2) @(negedge i_clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check_quiet("idle", 32'hA000_000F);
    end

    // Reset in the middle of a read burst.
    push_burst(0, 1'b0, 64'h1800);
    i_addr0 = 64'h1800;
    i_req0  = 1'b1;
    wait_idx(4'd5);
    #2;
    i_arst = 1'b1;
    i_req0 = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    gq.delete();
    check_quiet("midreset", 32'h0);
    repeat (2) @(negedge i_clk);
    i_arst = 1'b0;
    push_burst(0, 1'b0, 64'h0400);
    push_burst(1, 1'b0, 64'h0500);
    i_addr0 = 64'h0400;
    i_addr1 = 64'h0500;
    {i_req0, i_req1} = 2'b11;
    wait_done(0);
    i_req0 = 1'b0;
    wait_done(1);
    i_req1 = 1'b0;

    // Port 0 drops its request mid-burst while port 1 starts waiting.
    push_burst(0, 1'b0, 64'h3000);
    push_burst(1, 1'b0, 64'h3100);
    i_addr0 = 64'h3000;
    i_req0  = 1'b1;
    wait_idx(4'd3);
    i_req0  = 1'b0;
    i_addr1 = 64'h3100;
    i_req1  = 1'b1;
    wait_done(0);
    wait_done(1);
    i_req1  = 1'b0;

    repeat (5) @(negedge i_clk);
    check("queues_drained", 64'(q0.size() + q1.size() + gq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Round-robin arbiter and burst sequencer that shares the single variable-latency word memory port between two block-transfer requesters: port 0 is instruction fill and port 1 is data fill/write-back. It sits between the cache controllers and the memory model. For each granted request it performs a BLOCK_WORDS-word read or write burst, waiting on the memory's per-word completion pulse. It returns read words, or pulls write words, one at a time to the granted requester.

## Interface
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 64, byte address width.
- BLOCK_WORDS, 16, words per burst; power of two, ≥2. IDXW = log2(BLOCK_WORDS).
- Clock and reset: i_arst, asynchronous, active-high; clock i_clk.
- i_clk  in  1  clock.
- i_arst  in  1  async active-high reset.
- i_req0 / i_req1  in  1  burst request, held until matching o_done.
- i_we0 / i_we1  in  1  1 = write burst, 0 = read burst; sampled at grant.
- i_addr0 / i_addr1  in  ADDR_WIDTH  block base byte address; sampled at grant.
- i_wdata0 / i_wdata1  in  DATA_WIDTH  write word selected by o_word_idx; combinational from requester.
- o_gnt0 / o_gnt1  out  1  requester owns the memory (BUSY and DONE states).
- o_rvalid0 / o_rvalid1  out  1  one-cycle pulse, o_rdata holds a read word.
- o_done0 / o_done1  out  1  one-cycle burst-complete pulse.
- o_rdata  out  DATA_WIDTH  registered read word, shared.
- o_word_idx  out  IDXW  index of the word currently in flight.
- o_mem_addr  out  ADDR_WIDTH  memory byte address.
- o_mem_wdata  out  DATA_WIDTH  granted requester's i_wdata.
- o_mem_we  out  1  memory write enable.
- i_mem_rdata  in  DATA_WIDTH  memory read data, combinational on o_mem_addr.
- i_mem_access  in  1  memory word-complete pulse. The memory raises this pulse free-running, independent of any request.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:**
  - If any request is pending, grant it and go to BUSY.
  - Latch gnt_id, we and base = addr with the low log2(BLOCK_WORDS*4) bits cleared. Clear the word counter.
  - Arbitration: with a single request, grant it. With both requests, grant the port not granted last (round-robin).
  - After reset, last_gnt = 1, so port 0 wins the first tie.
- **BUSY:**
  - o_mem_addr = base + (word_idx << 2).
  - o_mem_we = latched we.
  - o_mem_wdata = i_wdata of the granted port.
  - On each i_mem_access:
    - For a read, o_rdata <= i_mem_rdata and o_rvalid(gnt) pulses the next cycle.
    - word_idx increments.
    - When word_idx == BLOCK_WORDS-1 at access, go to DONE instead.
  - Cycles without i_mem_access hold all outputs.
- **DONE:**
  - o_done(gnt) high for one cycle.
  - The last o_rvalid, for reads, coincides with o_done.
  - Update last_gnt. Go to IDLE.
- Deasserting a request mid-burst is ignored; the burst completes.
- i_we and i_addr changes after grant are ignored.
- i_mem_access in IDLE or DONE is ignored.
- Outside BUSY: o_mem_we = 0 and o_mem_addr = 0.
- o_mem_wdata outside BUSY is don't-care, driven 0.

## Timing
- Reset values:
  - State IDLE, last_gnt = 1, word_idx = 0.
  - All o_gnt, o_rvalid, o_done, o_mem_we, o_rdata and o_mem_addr are 0.
- Request sampled high in IDLE at edge t: BUSY from t+1, with o_gnt and o_mem_addr valid in cycle t+1.
- Each word completes in the cycle i_mem_access is high. The minimum is one cycle per word.
- A read word is visible on o_rdata/o_rvalid one cycle after its access.
- o_done is asserted the cycle after the last access. IDLE follows next, and a new grant takes effect the cycle after that. The gap between bursts is at least 2 cycles.
- Reset mid-burst aborts immediately; no o_done is issued.
- Word index wraps only via the transition to DONE; it never exceeds BLOCK_WORDS-1.

## Test plan
- **Single read, port 0:**
  - Stimulus: addr = 0x1004 (aligned to 0x1000), BLOCK_WORDS = 16, access pulses at random gaps.
  - Response: 16 o_rvalid0 pulses carrying mem[0x1000..0x103C], o_done0 together with the 16th pulse, o_gnt1 never high.
- **Simultaneous requests after reset:**
  - Response: port 0 is served first, then port 1. With both held continuously, grants alternate 0,1,0,1.
- **Write burst, port 1, base 0x2000:**
  - Requester returns 0xA000_0000 + idx.
  - Response: readback shows mem[0x2000 + 4k] = 0xA000_0000 + k. o_rvalid1 stays low.
- **i_mem_access pulses in IDLE with no requests:**
  - Response: no state change, o_mem_we = 0, no outputs toggle.
- **Reset at word 5 of a read burst:**
  - Response: all outputs return to 0 immediately, no o_done. The next request restarts at word 0 with port 0 winning a tie.
- **Port 0 drops i_req0 at word 3:**
  - Response: the burst still completes 16 words with o_done0. Only then is a pending i_req1 granted.
